// File: rtl/owr_slave.sv
// owr_slave: 1-Wire responder emulating a single DS18B20-style sensor.
// Samples and pulls the open-drain line to answer reset, ROM and function commands.
module owr_slave #(
  parameter int          CLK_MHZ     = 12,
  parameter logic [63:0] ROM_ID      = 64'h00_00_00_00_00_00_01_28,
  parameter int          RST_MIN_US  = 400,
  parameter int          SAMPLE_US   = 30,
  parameter int          PRES_DLY_US = 30,
  parameter int          PRES_LEN_US = 120
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_owr,
  output logic        o_owr,
  input  logic [15:0] i_temp,
  output logic        o_conv,
  output logic        o_active
);

  localparam logic [15:0] RST_CYC  = 16'(CLK_MHZ * RST_MIN_US);
  localparam logic [15:0] SMP_CYC  = 16'(CLK_MHZ * SAMPLE_US);
  localparam logic [15:0] PDLY_CYC = 16'(CLK_MHZ * PRES_DLY_US);
  localparam logic [15:0] PLEN_CYC = 16'(CLK_MHZ * PRES_LEN_US);

  typedef enum logic [2:0] {
    IDLE,
    PRES_WAIT,
    PRES,
    ROM_CMD,
    ROM_TX,
    FUNC_CMD,
    CONV,
    SP_TX
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] tmr_q, tmr_d;
  logic        rstf_q, rstf_d;
  logic        slot_q, slot_d;
  logic [6:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  crc_q, crc_d;
  logic [15:0] temp_q, temp_d;
  logic        owr_q, owr_d;
  logic        conv_q, conv_d;
  logic        active_q, active_d;

  logic        fall, rise, slot_fall;
  logic        tx_bit, crc_fb, byte_end;
  logic [7:0]  sp_byte, wr_byte, crc_nx;

  assign fall      = prev_q & ~sync2_q;
  assign rise      = ~prev_q & sync2_q;
  // A low we caused ourselves is never the start of a new slot
  assign slot_fall = fall & ~owr_q;
  assign wr_byte   = {sync2_q, shreg_q[7:1]};
  assign byte_end  = (bitcnt_q[2:0] == 3'd7);
  assign crc_fb    = crc_q[0] ^ tx_bit;
  assign crc_nx    = {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);

  always_comb begin
    case (bitcnt_q[6:3])
      4'd0:    sp_byte = temp_q[7:0];
      4'd1:    sp_byte = temp_q[15:8];
      4'd2:    sp_byte = 8'h4B;
      4'd3:    sp_byte = 8'h46;
      4'd4:    sp_byte = 8'h7F;
      4'd5:    sp_byte = 8'hFF;
      4'd6:    sp_byte = 8'h0C;
      4'd7:    sp_byte = 8'h10;
      default: sp_byte = crc_q;
    endcase
  end

  always_comb begin
    tx_bit = 1'b1;
    if (state_q == ROM_TX) begin
      tx_bit = ROM_ID[bitcnt_q[5:0]];
    end else if (state_q == SP_TX) begin
      tx_bit = sp_byte[bitcnt_q[2:0]];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = fall ? 16'd0 : ((&cnt_q) ? cnt_q : cnt_q + 16'd1);
    tmr_d    = tmr_q;
    rstf_d   = rstf_q;
    slot_d   = slot_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    crc_d    = crc_q;
    temp_d   = temp_q;
    owr_d    = owr_q;
    conv_d   = 1'b0;
    active_d = active_q;

    if (!sync2_q && !owr_q && cnt_q >= RST_CYC) begin
      rstf_d   = 1'b1;
      active_d = 1'b0;
    end

    if (rstf_q && rise) begin
      state_d  = PRES_WAIT;
      tmr_d    = 16'd0;
      rstf_d   = 1'b0;
      slot_d   = 1'b0;
      bitcnt_d = 7'd0;
      shreg_d  = 8'd0;
      crc_d    = 8'd0;
      owr_d    = 1'b0;
      active_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          slot_d = 1'b0;
        end
        PRES_WAIT: begin
          tmr_d = tmr_q + 16'd1;
          if (tmr_q == PDLY_CYC - 16'd1) begin
            state_d = PRES;
            tmr_d   = 16'd0;
            owr_d   = 1'b1;
          end
        end
        PRES: begin
          tmr_d = tmr_q + 16'd1;
          if (tmr_q == PLEN_CYC - 16'd1) begin
            state_d  = ROM_CMD;
            tmr_d    = 16'd0;
            owr_d    = 1'b0;
            active_d = 1'b1;
            slot_d   = 1'b0;
            bitcnt_d = 7'd0;
          end
        end
        ROM_CMD, FUNC_CMD: begin
          if (slot_fall) begin
            slot_d = 1'b1;
          end else if (slot_q && cnt_q == SMP_CYC) begin
            slot_d   = 1'b0;
            shreg_d  = wr_byte;
            bitcnt_d = byte_end ? 7'd0 : bitcnt_q + 7'd1;
            if (byte_end && state_q == ROM_CMD) begin
              case (wr_byte)
                8'hCC: state_d = FUNC_CMD;
                8'h33: state_d = ROM_TX;
                default: begin
                  state_d  = IDLE;
                  active_d = 1'b0;
                end
              endcase
            end else if (byte_end) begin
              case (wr_byte)
                8'h44: begin
                  state_d = CONV;
                  temp_d  = i_temp;
                  conv_d  = 1'b1;
                end
                8'hBE: begin
                  state_d = SP_TX;
                  crc_d   = 8'd0;
                end
                default: begin
                  state_d  = IDLE;
                  active_d = 1'b0;
                end
              endcase
            end
          end
        end
        ROM_TX, SP_TX: begin
          if (owr_q && cnt_q == SMP_CYC - 16'd1) begin
            owr_d = 1'b0;
          end
          if (slot_fall) begin
            slot_d = 1'b1;
            owr_d  = ~tx_bit;
          end else if (slot_q && rise) begin
            slot_d   = 1'b0;
            bitcnt_d = bitcnt_q + 7'd1;
            if (state_q == SP_TX && !bitcnt_q[6]) begin
              crc_d = crc_nx;
            end
            if ((state_q == ROM_TX && bitcnt_q == 7'd63) ||
                (state_q == SP_TX && bitcnt_q == 7'd71)) begin
              state_d  = IDLE;
              bitcnt_d = 7'd0;
              active_d = 1'b0;
            end
          end
        end
        CONV: begin
          slot_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      cnt_q    <= 16'd0;
      tmr_q    <= 16'd0;
      rstf_q   <= 1'b0;
      slot_q   <= 1'b0;
      bitcnt_q <= 7'd0;
      shreg_q  <= 8'd0;
      crc_q    <= 8'd0;
      temp_q   <= 16'h0550;
      owr_q    <= 1'b0;
      conv_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= i_owr;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      rstf_q   <= rstf_d;
      slot_q   <= slot_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      crc_q    <= crc_d;
      temp_q   <= temp_d;
      owr_q    <= owr_d;
      conv_q   <= conv_d;
      active_q <= active_d;
    end
  end

  assign o_owr    = owr_q;
  assign o_conv   = conv_q;
  assign o_active = active_q;

endmodule

// File: tb/tb_owr_slave.sv
// tb_owr_slave: directed bench for owr_slave acting as a bus master.
// Each scenario task drives slots and checks its own expectations inline.
module tb_owr_slave;

  localparam int          MHZ  = 2;
  localparam int          PDLY = 30 * MHZ;
  localparam int          PLEN = 120 * MHZ;
  localparam logic [63:0] ROM  = 64'hA5_6B_34_C2_78_9A_01_28;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_low = 1'b0;
  logic [15:0] temp = 16'h0000;
  logic        bus;
  logic        o_owr, o_conv, o_active;

  int n_chk = 0;
  int n_fail = 0;
  int drive_cnt = 0;
  int conv_cnt = 0;

  assign bus = ~(m_low | o_owr);

  owr_slave #(.CLK_MHZ(MHZ), .ROM_ID(ROM)) dut (
    .i_clk(clk), .i_rst(rst), .i_owr(bus), .o_owr(o_owr),
    .i_temp(temp), .o_conv(o_conv), .o_active(o_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_owr) drive_cnt <= drive_cnt + 1;
    if (o_conv) conv_cnt <= conv_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic us(input int n);
    cyc(n * MHZ);
  endtask

  task automatic write_bit(input logic b);
    m_low = 1'b1;
    if (b) begin
      us(6); m_low = 1'b0; us(59);
    end else begin
      us(60); m_low = 1'b0; us(5);
    end
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b1; us(3);
    m_low = 1'b0; us(12);
    b = bus;
    us(50);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic b;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v[i] = b;
    end
  endtask

  task automatic bus_reset();
    m_low = 1'b1; us(480);
    m_low = 1'b0; us(200);
  endtask

  function automatic logic [7:0] crc8(input logic [63:0] v);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = 0; i < 64; i++) begin
      fb = c[0] ^ v[i];
      c = {1'b0, c[7:1]};
      if (fb) c = c ^ 8'h8C;
    end
    return c;
  endfunction

  task automatic test_reset();
    int snap;
    cyc(4);
    n_chk++;
    if (o_owr !== 1'b0) begin n_fail++; $display("FAIL reset_owr: got %b want 0", o_owr); end
    n_chk++;
    if (o_conv !== 1'b0) begin n_fail++; $display("FAIL reset_conv: got %b want 0", o_conv); end
    n_chk++;
    if (o_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", o_active); end
    rst = 1'b0;
    snap = drive_cnt;
    cyc(100);
    n_chk++;
    if (drive_cnt != snap) begin n_fail++; $display("FAIL reset_idle_quiet: got %0d drive cycles want 0", drive_cnt - snap); end
  endtask

  task automatic test_presence();
    int n;
    m_low = 1'b1; us(480);
    m_low = 1'b0;
    n = 0;
    while (o_owr !== 1'b1 && n < 400) begin cyc(1); n++; end
    n_chk++;
    if (n < PDLY + 2 || n > PDLY + 4) begin
      n_fail++; $display("FAIL presence_delay: got %0d cycles want %0d..%0d", n, PDLY + 2, PDLY + 4);
    end
    n = 0;
    while (o_owr === 1'b1 && n < 2000) begin cyc(1); n++; end
    n_chk++;
    if (n != PLEN) begin n_fail++; $display("FAIL presence_len: got %0d cycles want %0d", n, PLEN); end
    n_chk++;
    if (o_active !== 1'b1) begin n_fail++; $display("FAIL presence_active: got %b want 1", o_active); end
    us(20);
  endtask

  task automatic test_rom_read();
    logic [63:0] got;
    logic b;
    bus_reset();
    write_byte(8'h33);
    for (int i = 0; i < 64; i++) begin
      read_bit(b);
      got[i] = b;
    end
    n_chk++;
    if (got !== ROM) begin n_fail++; $display("FAIL rom_id: got %h want %h", got, ROM); end
    n_chk++;
    if (o_active !== 1'b0) begin n_fail++; $display("FAIL rom_active_after: got %b want 0", o_active); end
  endtask

  task automatic test_convert();
    int csnap, dsnap;
    logic [3:0] r;
    logic b;
    bus_reset();
    write_byte(8'hCC);
    temp = 16'h0191;
    csnap = conv_cnt;
    write_byte(8'h44);
    temp = 16'h0000;
    cyc(5);
    n_chk++;
    if (conv_cnt - csnap != 1) begin n_fail++; $display("FAIL conv_pulse: got %0d cycles want 1", conv_cnt - csnap); end
    dsnap = drive_cnt;
    for (int i = 0; i < 4; i++) begin
      read_bit(b);
      r[i] = b;
    end
    n_chk++;
    if (r !== 4'hF) begin n_fail++; $display("FAIL conv_reads: got %b want 1111", r); end
    n_chk++;
    if (drive_cnt != dsnap) begin n_fail++; $display("FAIL conv_quiet: got %0d drive cycles want 0", drive_cnt - dsnap); end
  endtask

  task automatic test_scratchpad(input logic [15:0] t);
    logic [63:0] exp;
    logic [7:0]  v, want;
    exp = {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, t[15:8], t[7:0]};
    bus_reset();
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int i = 0; i < 9; i++) begin
      read_byte(v);
      want = (i < 8) ? exp[8*i +: 8] : crc8(exp);
      n_chk++;
      if (v !== want) begin n_fail++; $display("FAIL sp_byte%0d: got %h want %h", i, v, want); end
    end
    n_chk++;
    if (o_active !== 1'b0) begin n_fail++; $display("FAIL sp_active_after: got %b want 0", o_active); end
  endtask

  task automatic test_abort();
    logic [63:0] got;
    logic b;
    int snap;
    bus_reset();
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int i = 0; i < 20; i++) read_bit(b);
    m_low = 1'b1; us(480);
    n_chk++;
    if (o_active !== 1'b0) begin n_fail++; $display("FAIL abort_active_low: got %b want 0", o_active); end
    snap = drive_cnt;
    m_low = 1'b0; us(200);
    n_chk++;
    if (drive_cnt - snap != PLEN) begin n_fail++; $display("FAIL abort_presence: got %0d drive cycles want %0d", drive_cnt - snap, PLEN); end
    n_chk++;
    if (o_active !== 1'b1) begin n_fail++; $display("FAIL abort_active: got %b want 1", o_active); end
    write_byte(8'h33);
    for (int i = 0; i < 64; i++) begin
      read_bit(b);
      got[i] = b;
    end
    n_chk++;
    if (got !== ROM) begin n_fail++; $display("FAIL abort_rom_id: got %h want %h", got, ROM); end
  endtask

  task automatic test_unknown();
    logic [7:0] v;
    int snap;
    bus_reset();
    write_byte(8'hF0);
    n_chk++;
    if (o_active !== 1'b0) begin n_fail++; $display("FAIL unk_active: got %b want 0", o_active); end
    snap = drive_cnt;
    read_byte(v);
    n_chk++;
    if (v !== 8'hFF) begin n_fail++; $display("FAIL unk_reads: got %h want ff", v); end
    n_chk++;
    if (drive_cnt != snap) begin n_fail++; $display("FAIL unk_quiet: got %0d drive cycles want 0", drive_cnt - snap); end
  endtask

  task automatic test_rst_mid_presence();
    int n, snap;
    m_low = 1'b1; us(480);
    m_low = 1'b0;
    n = 0;
    while (o_owr !== 1'b1 && n < 400) begin cyc(1); n++; end
    n_chk++;
    if (o_owr !== 1'b1) begin n_fail++; $display("FAIL mid_pres_start: got %b want 1", o_owr); end
    cyc(10);
    rst = 1'b1;
    cyc(1);
    n_chk++;
    if (o_owr !== 1'b0) begin n_fail++; $display("FAIL mid_pres_owr: got %b want 0", o_owr); end
    rst = 1'b0;
    snap = drive_cnt;
    us(200);
    n_chk++;
    if (drive_cnt != snap) begin n_fail++; $display("FAIL mid_pres_quiet: got %0d drive cycles want 0", drive_cnt - snap); end
  endtask

  initial begin
    test_reset();
    test_presence();
    test_scratchpad(16'h0550);
    test_rom_read();
    test_convert();
    test_scratchpad(16'h0191);
    test_abort();
    test_unknown();
    test_rst_mid_presence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
